muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 141 ++++++++++++++
 tb/tb_muldiv_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit for the EX stage: MULT/MULTU via shift-add,
// DIV/DIVU via restoring division, results committed to HI/LO after a sign-fix cycle.
module muldiv_seq #(
  parameter int INST_SZ = 32,
  parameter int CNT_SZ  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start_E,
  input  logic [1:0]         i_op_E,
  input  logic [INST_SZ-1:0] i_operand_a_E,
  input  logic [INST_SZ-1:0] i_operand_b_E,
  input  logic               i_flush,
  output logic               o_stall_E,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero,
  output logic [INST_SZ-1:0] o_hi,
  output logic [INST_SZ-1:0] o_lo
);

  localparam int N = INST_SZ;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_SZ-1:0]   cnt;
  logic                div_op;
  logic [N-1:0]        m_reg;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*N-1:0]      acc;        // {partial product, multiplier} or {remainder, quotient}
  logic                neg_res, neg_rem, dz_flag;
  logic [N-1:0]        hi, lo;

  // Operand magnitudes and sign bits; op[0]=0 marks the signed variants.
  logic         sign_a, sign_b, accept, dz_start;
  logic [N-1:0] mag_a, mag_b;

  always_comb begin
    sign_a   = ~i_op_E[0] & i_operand_a_E[N-1];
    sign_b   = ~i_op_E[0] & i_operand_b_E[N-1];
    mag_a    = sign_a ? -i_operand_a_E : i_operand_a_E;
    mag_b    = sign_b ? -i_operand_b_E : i_operand_b_E;
    accept   = (state == IDLE) & i_start_E & ~i_flush;
    dz_start = accept & i_op_E[1] & (i_operand_b_E == '0);
  end

  // One radix-2 step of either algorithm.
  logic [N:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [2*N-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, m_reg} : '0);
    div_sh   = acc[2*N-1:N-1];
    div_ge   = div_sh >= {1'b0, m_reg};
    div_diff = div_sh - {1'b0, m_reg};
    if (div_op)
      acc_step = {(div_ge ? div_diff[N-1:0] : div_sh[N-1:0]), acc[N-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[N-1:1]};
  end

  // Sign correction applied to the unsigned result while in FIX.
  logic [2*N-1:0] prod;
  logic [N-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod = neg_res ? -acc : acc;
    if (div_op) begin
      fix_lo = neg_res ? -acc[N-1:0]     : acc[N-1:0];
      fix_hi = neg_rem ? -acc[2*N-1:N]   : acc[2*N-1:N];
    end else begin
      fix_lo = prod[N-1:0];
      fix_hi = prod[2*N-1:N];
    end
  end

  // NOTE: every combinational output gets a default before the case, so no latch can form.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = dz_start ? DONE : RUN;
      RUN:  if (cnt == CNT_SZ'(N - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dz_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        dz_flag <= dz_start;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (!i_flush) begin
        if (state == FIX) begin
          hi <= fix_hi;
          lo <= fix_lo;
        end else if (dz_start) begin
          hi <= i_operand_a_E;
          lo <= '1;
        end
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      div_op  <= i_op_E[1];
      m_reg   <= i_op_E[1] ? mag_b : mag_a;
      acc     <= {{N{1'b0}}, (i_op_E[1] ? mag_a : mag_b)};
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
    end else if (state == RUN) begin
      acc <= acc_step;
    end
  end

  always_comb begin
    o_busy     = state != IDLE;
    o_done     = (state == DONE) & ~i_flush;
    o_div_zero = o_done & dz_flag;
    o_stall_E  = i_rst_n & (((state == IDLE) & i_start_E) | (state == RUN) | (state == FIX));
    o_hi       = hi;
    o_lo       = lo;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: hand-computed results, latency, stall window,
// flush and asynchronous reset behaviour.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         stall, busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.INST_SZ(W), .CNT_SZ(6)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_E     (start),
    .i_op_E        (op),
    .i_operand_a_E (a),
    .i_operand_b_E (b),
    .i_flush       (flush),
    .o_stall_E     (stall),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_zero    (div_zero),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation and follow it to o_done. Edges are counted from the accepting
  // edge inclusive; stall cycles are those sampled after the accepting edge before done.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input bit hold, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_edges,
                       input int exp_stall);
    int  edges = 1;
    int  stalls = 0;
    bit  seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    while (edges < 100) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (stall) stalls++;
      @(posedge clk);
      edges++;
    end
    check({tag, " timeout"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_stall));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check({tag, " stall_in_done"}, 64'(stall), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    #1;
    check("reset_outputs", {busy, done, div_zero, stall}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // -3 * 7 = -21 as a 64-bit product.
    do_op("mult", 2'b00, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33);
    do_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001,
          1'b0, 34, 33);
    // -7 / 2 = -3 remainder -1.
    do_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 33);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000,
          1'b0, 34, 33);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, 32'h64, 32'hFFFF_FFFF, 1'b1, 1, 0);
    // Start held for the whole operation: one op only, no re-accept in DONE.
    do_op("mult_hold", 2'b00, 32'd5, 32'd6, 1, 32'h0, 32'd30, 1'b0, 34, 33);

    // Flush ten cycles into RUN: back to IDLE, HI/LO keep 0/30, no done.
    begin
      bit done_seen = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      check("flush_running", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {62'd0, busy, done}, 64'd0);
      check("flush_hilo", {hi, lo}, {32'h0, 32'd30});
      repeat (40) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      check("flush_no_done", 64'(done_seen), 64'd0);
    end

    // Flush wins over a simultaneous start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_vs_start", 64'(busy), 64'd0);

    // Asynchronous reset mid-RUN clears everything without a clock edge.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {busy, done, div_zero, stall}, 64'd0);
    check("rst_async_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    check("rst_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    do_op("divu_after_rst", 2'b11, 32'd9, 32'd4, 0, 32'd1, 32'd2, 1'b0, 34, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
